// File: rtl/key_cmd_decoder.sv
// rtl/key_cmd_decoder.sv - PS/2 scan-code window to one-cycle LifeGame command decoder
//
// Waits for the receiver's xkey window to stop changing and then decodes it
// as a make or break code. It emits one-cycle game commands and generates
// auto-repeat for a held direction key.
//
// Ports:
//   clk_25mhz  in   1   system clock
//   clr        in   1   asynchronous active-high reset
//   xkey       in  16   {previous byte, latest byte}, asynchronous to clk_25mhz
//   cmd_valid  out  1   one-cycle pulse, cmd is valid
//   cmd        out  3   1 up, 2 down, 3 left, 4 right, 5 toggle, 6 run/pause, 7 clear
//   key_held   out  1   high while a direction key is held
module key_cmd_decoder #(
    parameter int STABLE_CYC = 4000,
    parameter int REPEAT_DLY = 12500000,
    parameter int REPEAT_PER = 2500000
) (
    input  logic        clk_25mhz,
    input  logic        clr,
    input  logic [15:0] xkey,
    output logic        cmd_valid,
    output logic [2:0]  cmd,
    output logic        key_held
);

    localparam logic [12:0] STAB_MAX   = 13'(STABLE_CYC);
    localparam logic [12:0] STAB_LAST  = 13'(STABLE_CYC - 1);
    localparam logic [23:0] REP_DLY_LD = 24'(REPEAT_DLY - 1);
    localparam logic [23:0] REP_PER_LD = 24'(REPEAT_PER - 1);

    typedef enum logic {IDLE, HELD} state_t;

    state_t      state;
    logic [15:0] x_s1, xs, xs_prev, last_acc;
    logic [12:0] stab_cnt;
    logic [23:0] rep_cnt;
    logic [2:0]  dir;

    logic        accept;
    logic [7:0]  hi, lo;
    logic        is_prefix, is_break;
    logic [2:0]  key_code, make_code, brk_code;

    function automatic logic [2:0] map_key(input logic [7:0] code);
        case (code)
            8'h1D, 8'h75: map_key = 3'd1;
            8'h1B, 8'h72: map_key = 3'd2;
            8'h1C, 8'h6B: map_key = 3'd3;
            8'h23, 8'h74: map_key = 3'd4;
            8'h29:        map_key = 3'd5;
            8'h5A:        map_key = 3'd6;
            8'h2D:        map_key = 3'd7;
            default:      map_key = 3'd0;
        endcase
    endfunction

    function automatic logic is_dir(input logic [2:0] code);
        is_dir = (code != 3'd0) && (code <= 3'd4);
    endfunction

    // A window counts as a completed frame once it has been stable long
    // enough. Comparing against last_acc stops a held window from re-firing.
    always_comb begin
        accept    = (stab_cnt == STAB_LAST) && (xs == xs_prev) && (xs != last_acc);
        hi        = xs[15:8];
        lo        = xs[7:0];
        is_prefix = (lo == 8'hF0) || (lo == 8'hE0);
        is_break  = (hi == 8'hF0);
        key_code  = map_key(lo);
        make_code = (accept && !is_prefix && !is_break) ? key_code : 3'd0;
        brk_code  = (accept && !is_prefix &&  is_break) ? key_code : 3'd0;
    end

    always_ff @(posedge clk_25mhz or posedge clr) begin
        if (clr) begin
            x_s1     <= 16'h0000;
            xs       <= 16'h0000;
            xs_prev  <= 16'h0000;
            stab_cnt <= 13'd0;
            last_acc <= 16'h0000;
        end else begin
            x_s1    <= xkey;
            xs      <= x_s1;
            xs_prev <= xs;
            if (xs != xs_prev)
                stab_cnt <= 13'd0;
            else if (stab_cnt != STAB_MAX)
                stab_cnt <= stab_cnt + 13'd1;
            if (accept)
                last_acc <= xs;
        end
    end

    always_ff @(posedge clk_25mhz or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            cmd_valid <= 1'b0;
            cmd       <= 3'd0;
            key_held  <= 1'b0;
            dir       <= 3'd0;
            rep_cnt   <= 24'd0;
        end else begin
            cmd_valid <= 1'b0;
            cmd       <= 3'd0;
            case (state)
                IDLE: begin
                    if (make_code != 3'd0) begin
                        cmd_valid <= 1'b1;
                        cmd       <= make_code;
                        if (is_dir(make_code)) begin
                            dir      <= make_code;
                            rep_cnt  <= REP_DLY_LD;
                            state    <= HELD;
                            key_held <= 1'b1;
                        end
                    end
                end
                HELD: begin
                    if (accept) begin
                        // Any accept pre-empts a repeat that is due this cycle.
                        rep_cnt <= (rep_cnt == 24'd0) ? REP_PER_LD : rep_cnt - 24'd1;
                        if (brk_code != 3'd0 && brk_code == dir) begin
                            state    <= IDLE;
                            key_held <= 1'b0;
                        end else if (make_code != 3'd0 && make_code != dir) begin
                            cmd_valid <= 1'b1;
                            cmd       <= make_code;
                            if (is_dir(make_code)) begin
                                dir     <= make_code;
                                rep_cnt <= REP_DLY_LD;
                            end
                        end
                    end else if (rep_cnt == 24'd0) begin
                        cmd_valid <= 1'b1;
                        cmd       <= dir;
                        rep_cnt   <= REP_PER_LD;
                    end else begin
                        rep_cnt <= rep_cnt - 24'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_cmd_decoder.sv
// tb/tb_key_cmd_decoder.sv - scoreboard bench for key_cmd_decoder
module tb_key_cmd_decoder;

    localparam int S   = 16;
    localparam int DLY = 300;
    localparam int PER = 80;
    localparam int GL  = 3;

    logic        clk_25mhz = 1'b0;
    logic        clr = 1'b1;
    logic [15:0] xkey = 16'h0000;
    logic        cmd_valid;
    logic [2:0]  cmd;
    logic        key_held;

    key_cmd_decoder #(.STABLE_CYC(S), .REPEAT_DLY(DLY), .REPEAT_PER(PER)) dut (
        .clk_25mhz(clk_25mhz),
        .clr(clr),
        .xkey(xkey),
        .cmd_valid(cmd_valid),
        .cmd(cmd),
        .key_held(key_held)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    int cyc = 0;
    always @(posedge clk_25mhz) cyc <= cyc + 1;

    typedef struct { int t; logic [2:0] c; } pulse_t;
    typedef struct { int t; logic v; } kh_t;
    typedef struct { int kind; logic [15:0] v; int t; int len; } step_t;

    pulse_t exp_q[$];
    kh_t    kh_q[$];
    step_t  plan[$];

    int total = 0;
    int bad = 0;

    int          keymap[256];
    bit          m_held = 0;
    int          m_dir = 0;
    int          m_next = 0;
    logic [15:0] m_last = 16'h0000;
    logic [15:0] cur_x = 16'h0000;
    int          now = 0;

    // Reference model: event-level view of the decoder, computed on the plan.
    task automatic model_flush(input int limit);
        while (m_held && m_next < limit) begin
            exp_q.push_back('{m_next, 3'(m_dir)});
            m_next += PER;
        end
    endtask

    task automatic model_change(input int c, input logic [15:0] v);
        int p;
        int k;
        logic [7:0] hi;
        logic [7:0] lo;
        p = c + S + 3;
        model_flush(p);
        if (v == m_last) return;
        m_last = v;
        hi = v[15:8];
        lo = v[7:0];
        k = keymap[lo];
        if (m_held && m_next == p) m_next = p + PER;
        if (lo == 8'hF0 || lo == 8'hE0 || k == 0) return;
        if (hi == 8'hF0) begin
            if (m_held && k == m_dir) begin
                m_held = 0;
                kh_q.push_back('{p, 1'b0});
            end
        end else if (!(m_held && k == m_dir)) begin
            exp_q.push_back('{p, 3'(k)});
            if (k <= 4) begin
                if (!m_held) kh_q.push_back('{p, 1'b1});
                m_held = 1;
                m_dir = k;
                m_next = p + DLY;
            end
        end
    endtask

    task automatic add_key(input logic [15:0] v, input int ng, input int hold);
        logic [15:0] g;
        for (int i = 0; i < ng; i++) begin
            g = v ^ 16'($urandom_range(1, 65535));
            plan.push_back('{2, g, now, 0});
            now += GL;
        end
        plan.push_back('{0, v, now, 0});
        model_change(now, v);
        cur_x = v;
        now += hold;
    endtask

    task automatic add_clr(input int len, input int hold);
        model_flush(now);
        if (m_held) kh_q.push_back('{now, 1'b0});
        m_held = 0;
        m_last = 16'h0000;
        plan.push_back('{1, cur_x, now, len});
        now += len;
        model_change(now, cur_x);
        now += hold;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk_25mhz);
            #1;
        end
    endtask

    logic exp_kh = 1'b0;
    always @(negedge clk_25mhz) begin
        pulse_t e;
        while (kh_q.size() > 0 && kh_q[0].t <= cyc) exp_kh = kh_q.pop_front().v;
        total++;
        if (key_held !== exp_kh) begin
            bad++;
            $display("FAIL key_held cyc=%0d: got %b want %b", cyc, key_held, exp_kh);
        end
        while (exp_q.size() > 0 && exp_q[0].t < cyc) begin
            e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL missing_pulse: got none by cyc=%0d want cmd=%0d at cyc=%0d", cyc, e.c, e.t);
        end
        if (cmd_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL extra_pulse: got cmd=%0d at cyc=%0d want no pulse", cmd, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.t != cyc || e.c !== cmd) begin
                    bad++;
                    $display("FAIL pulse: got cmd=%0d at cyc=%0d want cmd=%0d at cyc=%0d", cmd, cyc, e.c, e.t);
                end
            end
        end else begin
            total++;
            if (cmd_valid !== 1'b0 || cmd !== 3'd0) begin
                bad++;
                $display("FAIL idle_out cyc=%0d: got valid=%b cmd=%0d want 0/0", cyc, cmd_valid, cmd);
            end
        end
    end

    logic [7:0] lo_tab[14] = '{8'h1D, 8'h75, 8'h1B, 8'h72, 8'h1C, 8'h6B, 8'h23,
                               8'h74, 8'h29, 8'h5A, 8'h2D, 8'hF0, 8'hE0, 8'h00};

    initial begin
        logic [7:0] hi;
        logic [7:0] lo;
        int hold;
        for (int i = 0; i < 256; i++) keymap[i] = 0;
        keymap['h1D] = 1; keymap['h75] = 1;
        keymap['h1B] = 2; keymap['h72] = 2;
        keymap['h1C] = 3; keymap['h6B] = 3;
        keymap['h23] = 4; keymap['h74] = 4;
        keymap['h29] = 5; keymap['h5A] = 6; keymap['h2D] = 7;

        // Directed scenarios.
        add_clr(3, 2000);
        add_key(16'h001D, 8, DLY + 3 * PER + 40);
        add_key(16'h1DF0, 0, 50);
        add_key(16'hF01D, 0, 300);
        add_key(16'hE06B, 2, 50);
        add_key(16'hE0F0, 0, 50);
        add_key(16'hF06B, 0, 60);
        add_key(16'h001D, 0, 100);
        add_key(16'h1D29, 1, 300);
        add_key(16'h2974, 0, 400);
        add_key(16'hF074, 0, 60);
        add_key(16'h0075, 0, 60);
        add_key(16'h755A, 0, 60);
        add_clr(5, 100);

        // Randomized scenarios.
        for (int n = 0; n < 40; n++) begin
            lo = lo_tab[$urandom_range(0, 13)];
            if (lo == 8'h00) lo = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 5))
                0: hi = 8'h00;
                1, 2: hi = 8'hF0;
                3: hi = 8'hE0;
                4: hi = cur_x[7:0];
                default: hi = 8'($urandom_range(0, 255));
            endcase
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(DLY, DLY + 3 * PER)
                                                : $urandom_range(S + 6, S + 80);
            add_key({hi, lo}, $urandom_range(0, 3), hold);
            if ($urandom_range(0, 15) == 0) add_clr($urandom_range(1, 6), S + 30);
        end
        add_key(16'h0000, 0, S + 30);
        add_clr(5, S + 30);

        // Driver.
        foreach (plan[i]) begin
            wait_until(plan[i].t);
            if (plan[i].kind == 1) begin
                clr = 1'b1;
                wait_until(plan[i].t + plan[i].len);
                clr = 1'b0;
            end else begin
                xkey = plan[i].v;
            end
        end
        wait_until(now + S + 20);
        while (exp_q.size() > 0) begin
            pulse_t e;
            e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL missing_pulse_end: got none want cmd=%0d at cyc=%0d", e.c, e.t);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
